// File: rtl/data_sram_if.sv
// rtl/data_sram_if.sv - CPU data SRAM bus bundle between core (master) and responder (slave)
interface data_sram_if;
   logic        data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_we,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_we,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder: word RAM plus LED/NUM/SWITCH/TIMER/WCNT window, 1-cycle read
module data_sram_responder #(
   parameter int          ADDR_W    = 14,
   parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
   input  logic        clk,
   input  logic        resetn,
   data_sram_if.slave  bus,
   input  logic [15:0] switch_in,
   output logic [15:0] led_out,
   output logic [31:0] num_out
);

   // word offsets (byte offset >> 2) inside the config window
   localparam logic [13:0] OFF_LED   = 14'h3c00;
   localparam logic [13:0] OFF_NUM   = 14'h3c04;
   localparam logic [13:0] OFF_SW    = 14'h3c08;
   localparam logic [13:0] OFF_WCNT  = 14'h3c0c;
   localparam logic [13:0] OFF_TIMER = 14'h3800;

   logic [31:0] mem [2**ADDR_W];
   logic [31:0] ram_rd_q;
   logic        sel_ram_q;
   logic [31:0] conf_rd_q, conf_rd_d;
   logic [15:0] led_q;
   logic [31:0] num_q;
   logic [31:0] timer_q, timer_d;
   logic [31:0] wcnt_q;

   logic              conf_hit;
   logic [13:0]       off;
   logic [ADDR_W-1:0] ram_idx;
   logic              unused_addr_lsb;

   assign conf_hit        = (bus.data_sram_addr[31:16] == CONF_BASE);
   assign off             = bus.data_sram_addr[15:2];
   assign ram_idx         = bus.data_sram_addr[ADDR_W+1:2];
   assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

   // read-before-write: the registered read captures the old word
   always_ff @(posedge clk) begin
      if (resetn) begin
         if (bus.data_sram_we && !conf_hit) begin
            mem[ram_idx] <= bus.data_sram_wdata;
         end
         ram_rd_q <= mem[ram_idx];
      end
   end

   always_comb begin
      conf_rd_d = 32'h0;
      if (conf_hit) begin
         case (off)
            OFF_LED:   conf_rd_d = {16'h0, led_q};
            OFF_NUM:   conf_rd_d = num_q;
            OFF_SW:    conf_rd_d = {16'h0, switch_in};
            OFF_WCNT:  conf_rd_d = wcnt_q;
            OFF_TIMER: conf_rd_d = timer_q;
            default:   conf_rd_d = 32'h0;
         endcase
      end
   end

   always_comb begin
      timer_d = timer_q + 32'd1;
      if (bus.data_sram_we && conf_hit && off == OFF_TIMER) begin
         timer_d = bus.data_sram_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sel_ram_q <= 1'b0;
         conf_rd_q <= 32'h0;
         led_q     <= 16'h0;
         num_q     <= 32'h0;
         timer_q   <= 32'h0;
         wcnt_q    <= 32'h0;
      end else begin
         sel_ram_q <= !conf_hit;
         conf_rd_q <= conf_rd_d;
         timer_q   <= timer_d;
         if (bus.data_sram_we) begin
            wcnt_q <= wcnt_q + 32'd1;
            if (conf_hit && off == OFF_LED) begin
               led_q <= bus.data_sram_wdata[15:0];
            end
            if (conf_hit && off == OFF_NUM) begin
               num_q <= bus.data_sram_wdata;
            end
         end
      end
   end

   assign bus.data_sram_rdata = sel_ram_q ? ram_rd_q : conf_rd_q;
   assign led_out             = led_q;
   assign num_out             = num_q;

endmodule
